// File: rtl/cdc_bus_rx_pkg.sv
// Shared constants for the cdc_bus_rx receiver.
// The synchronizer depth macro is normally supplied by the integrator's params.vh.
`ifndef pSYNC_STAGES
`define pSYNC_STAGES 2
`endif

package cdc_bus_rx_pkg;

    // Metastability protection needs at least two stages.
    localparam int unsigned SYNC_STAGES = (`pSYNC_STAGES < 2) ? 2 : `pSYNC_STAGES;
    localparam int unsigned COUNT_W     = 16;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit level synchronizer: DEPTH flops in series, cleared by reset.
import cdc_bus_rx_pkg::*;

module cdc_sync_bit #(
    parameter int unsigned DEPTH = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[DEPTH-2:0], d};
        end
    end

    assign q = sync_ff[DEPTH-1];

endmodule

// File: rtl/cdc_bus_rx.sv
// Destination side of a 4-phase req/ack bundled-data crossing.
// Captures src_data once the synchronized request is seen and hands it downstream.
import cdc_bus_rx_pkg::*;

module cdc_bus_rx #(
    parameter int unsigned pDATA_WIDTH = 32
) (
    input  logic                   dst_clk,
    input  logic                   dst_rst_n,
    input  logic                   src_req,
    input  logic [pDATA_WIDTH-1:0] src_data,
    output logic                   src_ack,
    output logic [pDATA_WIDTH-1:0] dst_data,
    output logic                   dst_valid,
    input  logic                   dst_ready,
    output logic                   proto_err,
    output logic [COUNT_W-1:0]     xfer_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VALID  = 2'd1,
        ACK_HI = 2'd2
    } state_t;

    state_t state;
    logic   req_s;

    cdc_sync_bit #(
        .DEPTH(SYNC_STAGES)
    ) u_req_sync (
        .clk   (dst_clk),
        .rst_n (dst_rst_n),
        .d     (src_req),
        .q     (req_s)
    );

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            state      <= IDLE;
            src_ack    <= 1'b0;
            dst_data   <= '0;
            dst_valid  <= 1'b0;
            proto_err  <= 1'b0;
            xfer_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    src_ack <= 1'b0;
                    if (req_s) begin
                        dst_data  <= src_data;
                        dst_valid <= 1'b1;
                        state     <= VALID;
                    end
                end
                VALID: begin
                    // Sender withdrew before being acknowledged; the word is still delivered.
                    if (!req_s) begin
                        proto_err <= 1'b1;
                    end
                    if (dst_ready) begin
                        dst_valid  <= 1'b0;
                        src_ack    <= 1'b1;
                        xfer_count <= xfer_count + 16'd1;
                        state      <= ACK_HI;
                    end
                end
                ACK_HI: begin
                    if (!req_s) begin
                        src_ack <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    src_ack   <= 1'b0;
                    dst_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_bus_rx.sv
// Directed self-checking bench for cdc_bus_rx with a 2-stage synchronizer and 32-bit data.
module tb_cdc_bus_rx;

    logic        dst_clk;
    logic        dst_rst_n;
    logic        src_req;
    logic [31:0] src_data;
    logic        src_ack;
    logic [31:0] dst_data;
    logic        dst_valid;
    logic        dst_ready;
    logic        proto_err;
    logic [15:0] xfer_count;

    int checks;
    int failures;

    cdc_bus_rx #(
        .pDATA_WIDTH(32)
    ) dut (
        .dst_clk    (dst_clk),
        .dst_rst_n  (dst_rst_n),
        .src_req    (src_req),
        .src_data   (src_data),
        .src_ack    (src_ack),
        .dst_data   (dst_data),
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready),
        .proto_err  (proto_err),
        .xfer_count (xfer_count)
    );

    initial dst_clk = 1'b0;
    always #5 dst_clk = ~dst_clk;

    // Advance one rising edge and settle; inputs changed afterwards meet setup for the next edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge dst_clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tick(2);
        checks++; if (src_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", src_ack); end
        checks++; if (dst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dst_valid); end
        checks++; if (dst_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", dst_data); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", proto_err); end
        checks++; if (xfer_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", xfer_count); end
        dst_rst_n = 1'b1;
        tick(1);
    endtask

    task automatic release_req;
        int n;
        src_req = 1'b0;
        n = 0;
        while (src_ack !== 1'b0 && n < 10) begin tick(1); n++; end
        checks++; if (src_ack !== 1'b0) begin failures++; $display("FAIL release_timeout ack=%b exp=0", src_ack); end
    endtask

    task automatic test_single;
        src_data = 32'hDEADBEEF; dst_ready = 1'b1; src_req = 1'b1;
        tick(2);
        checks++; if (dst_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", dst_valid); end
        tick(1);
        checks++; if (dst_valid !== 1'b1) begin failures++; $display("FAIL single_valid_e3 got=%b exp=1", dst_valid); end
        checks++; if (dst_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", dst_data); end
        checks++; if (src_ack !== 1'b0) begin failures++; $display("FAIL single_ack_early got=%b exp=0", src_ack); end
        tick(1);
        checks++; if (src_ack !== 1'b1) begin failures++; $display("FAIL single_ack got=%b exp=1", src_ack); end
        checks++; if (dst_valid !== 1'b0) begin failures++; $display("FAIL single_valid_clr got=%b exp=0", dst_valid); end
        checks++; if (xfer_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", xfer_count); end
        release_req();
    endtask

    task automatic test_backpressure;
        int bad;
        src_data = 32'hA5A50F0F; dst_ready = 1'b0; src_req = 1'b1;
        tick(3);
        checks++; if (dst_valid !== 1'b1) begin failures++; $display("FAIL bp_capture got=%b exp=1", dst_valid); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            src_data = 32'h11111111 * (i + 1);
            tick(1);
            if (dst_valid !== 1'b1 || dst_data !== 32'hA5A50F0F || src_ack !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0 valid=%b data=%h ack=%b", bad, dst_valid, dst_data, src_ack); end
        src_data = 32'hA5A50F0F;
        dst_ready = 1'b1;
        tick(1);
        checks++; if (src_ack !== 1'b1) begin failures++; $display("FAIL bp_ack got=%b exp=1", src_ack); end
        checks++; if (dst_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_clr got=%b exp=0", dst_valid); end
        checks++; if (xfer_count !== 16'd2) begin failures++; $display("FAIL bp_count got=%0d exp=2", xfer_count); end
    endtask

    // Continues from the ACK_HI state left by test_backpressure, with src_req still high.
    task automatic test_four_phase;
        int bad;
        src_data = 32'h12345678;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (src_ack !== 1'b1 || dst_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL fp_ack_hold bad_cycles=%0d exp=0", bad); end
        src_req = 1'b0;
        tick(1);
        checks++; if (src_ack !== 1'b1) begin failures++; $display("FAIL fp_ack_e1 got=%b exp=1", src_ack); end
        tick(2);
        checks++; if (src_ack !== 1'b0) begin failures++; $display("FAIL fp_ack_fall got=%b exp=0", src_ack); end
        checks++; if (dst_valid !== 1'b0) begin failures++; $display("FAIL fp_no_early_capture got=%b exp=0", dst_valid); end
        src_req = 1'b1;
        tick(3);
        checks++; if (dst_valid !== 1'b1) begin failures++; $display("FAIL fp_next_valid got=%b exp=1", dst_valid); end
        checks++; if (dst_data !== 32'h12345678) begin failures++; $display("FAIL fp_next_data got=%h exp=12345678", dst_data); end
        tick(1);
        checks++; if (xfer_count !== 16'd3) begin failures++; $display("FAIL fp_count got=%0d exp=3", xfer_count); end
        release_req();
    endtask

    task automatic do_xfer(input logic [31:0] word);
        int n;
        src_data = word; dst_ready = 1'b1; src_req = 1'b1;
        n = 0;
        while (src_ack !== 1'b1 && n < 12) begin tick(1); n++; end
        checks++; if (src_ack !== 1'b1) begin failures++; $display("FAIL xfer_timeout ack=%b exp=1", src_ack); end
        release_req();
    endtask

    task automatic test_wrap;
        tick(1);
        force dut.xfer_count = 16'hFFFE;
        tick(1);
        release dut.xfer_count;
        tick(1);
        do_xfer(32'h00000001);
        checks++; if (xfer_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", xfer_count); end
        do_xfer(32'h00000002);
        checks++; if (xfer_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", xfer_count); end
        checks++; if (dst_valid !== 1'b0 || src_ack !== 1'b0 || proto_err !== 1'b0) begin
            failures++; $display("FAIL wrap_side_effect valid=%b ack=%b err=%b exp=0,0,0", dst_valid, src_ack, proto_err);
        end
        checks++; if (dst_data !== 32'h00000002) begin failures++; $display("FAIL wrap_data got=%h exp=00000002", dst_data); end
    endtask

    task automatic test_proto_err;
        src_data = 32'hCAFEF00D; dst_ready = 1'b0; src_req = 1'b1;
        tick(3);
        checks++; if (dst_valid !== 1'b1) begin failures++; $display("FAIL pe_capture got=%b exp=1", dst_valid); end
        src_req = 1'b0;
        tick(2);
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL pe_early got=%b exp=0", proto_err); end
        tick(1);
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL pe_set got=%b exp=1", proto_err); end
        checks++; if (dst_valid !== 1'b1 || dst_data !== 32'hCAFEF00D) begin
            failures++; $display("FAIL pe_word_held valid=%b data=%h exp=1 cafef00d", dst_valid, dst_data);
        end
        dst_ready = 1'b1;
        tick(1);
        checks++; if (src_ack !== 1'b1 || dst_valid !== 1'b0) begin failures++; $display("FAIL pe_deliver ack=%b valid=%b exp=1 0", src_ack, dst_valid); end
        checks++; if (xfer_count !== 16'd1) begin failures++; $display("FAIL pe_count got=%0d exp=1", xfer_count); end
        tick(1);
        checks++; if (src_ack !== 1'b0) begin failures++; $display("FAIL pe_ack_clr got=%b exp=0", src_ack); end
        tick(5);
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL pe_sticky got=%b exp=1", proto_err); end
    endtask

    task automatic test_reset_mid_ack;
        src_data = 32'h0BADF00D; dst_ready = 1'b1; src_req = 1'b1;
        tick(4);
        checks++; if (src_ack !== 1'b1) begin failures++; $display("FAIL rm_in_ack got=%b exp=1", src_ack); end
        #2 dst_rst_n = 1'b0;
        #1;
        checks++; if (src_ack !== 1'b0 || dst_valid !== 1'b0 || dst_data !== 32'h0) begin
            failures++; $display("FAIL rm_async ack=%b valid=%b data=%h exp=0 0 0", src_ack, dst_valid, dst_data);
        end
        checks++; if (proto_err !== 1'b0 || xfer_count !== 16'h0) begin
            failures++; $display("FAIL rm_async_err_cnt err=%b count=%h exp=0 0000", proto_err, xfer_count);
        end
        src_data = 32'h55AA55AA;
        tick(2);
        dst_rst_n = 1'b1;
        tick(2);
        checks++; if (dst_valid !== 1'b0) begin failures++; $display("FAIL rm_early_valid got=%b exp=0", dst_valid); end
        tick(1);
        checks++; if (dst_valid !== 1'b1) begin failures++; $display("FAIL rm_valid_e3 got=%b exp=1", dst_valid); end
        checks++; if (dst_data !== 32'h55AA55AA) begin failures++; $display("FAIL rm_data got=%h exp=55aa55aa", dst_data); end
        tick(1);
        checks++; if (xfer_count !== 16'd1) begin failures++; $display("FAIL rm_count got=%0d exp=1", xfer_count); end
        release_req();
    endtask

    initial begin
        checks = 0; failures = 0;
        dst_rst_n = 1'b0; src_req = 1'b0; src_data = '0; dst_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_four_phase();
        test_wrap();
        test_proto_err();
        test_reset_mid_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
